// File: rtl/ballot_scheduler_if.sv
// Signal bundle between the booth front-ends, ballot_scheduler and the vote counter.
// BALLOT_TALLY_EN adds the total_ballots / tally_sat outputs.
interface ballot_scheduler_if #(
   parameter int unsigned NUM_BOOTHS = 4
);
   logic                    session_open;
   logic [NUM_BOOTHS-1:0]   booth_req;
   logic [3*NUM_BOOTHS-1:0] booth_cand;
   logic [NUM_BOOTHS-1:0]   booth_ack;
   logic [NUM_BOOTHS-1:0]   booth_err;
   logic                    vote_A;
   logic                    vote_B;
   logic                    vote_C;
   logic                    vote_D;
   logic                    vote_E;
   logic [2:0]              grant_id;
   logic                    busy;
`ifdef BALLOT_TALLY_EN
   logic [7:0]              total_ballots;
   logic                    tally_sat;

   modport master (
      output session_open, booth_req, booth_cand,
      input  booth_ack, booth_err, vote_A, vote_B, vote_C, vote_D, vote_E,
      input  grant_id, busy, total_ballots, tally_sat
   );

   modport slave (
      input  session_open, booth_req, booth_cand,
      output booth_ack, booth_err, vote_A, vote_B, vote_C, vote_D, vote_E,
      output grant_id, busy, total_ballots, tally_sat
   );
`else
   modport master (
      output session_open, booth_req, booth_cand,
      input  booth_ack, booth_err, vote_A, vote_B, vote_C, vote_D, vote_E,
      input  grant_id, busy
   );

   modport slave (
      input  session_open, booth_req, booth_cand,
      output booth_ack, booth_err, vote_A, vote_B, vote_C, vote_D, vote_E,
      output grant_id, busy
   );
`endif
endinterface

// File: rtl/ballot_scheduler.sv
// Round-robin ballot scheduler: serialises booth requests onto one-hot vote pulses.
// Optional macro BALLOT_TALLY_EN adds a saturating count of accepted ballots.
module ballot_scheduler #(
   parameter int unsigned NUM_BOOTHS = 4,
   parameter int unsigned HOLDOFF    = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   ballot_scheduler_if.slave bus
);
   localparam int unsigned IDW   = 3;
   localparam int unsigned CNTW  = 4;
   localparam int unsigned NVOTE = 5;

   typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_e;

   state_e                state_q, state_d;
   logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]        grant_id_q, grant_id_d;
   logic [NUM_BOOTHS-1:0] armed_q, armed_d;
   logic [NUM_BOOTHS-1:0] ack_q, ack_d;
   logic [NUM_BOOTHS-1:0] err_q, err_d;
   logic [NVOTE-1:0]      vote_q, vote_d;
   logic [CNTW-1:0]       hold_q, hold_d;
   logic                  busy_q, busy_d;

   logic [NUM_BOOTHS-1:0]   eligible_c;
   logic [NUM_BOOTHS-1:0]   elig_rot_c;
   logic [NUM_BOOTHS-1:0]   sel_c;
   logic [3*NUM_BOOTHS-1:0] cand_sh_c;
   logic [IDW-1:0]          winner_c;
   logic [IDW-1:0]          cand_c;
   logic                    found_c;
   int unsigned             idx_c;

   assign eligible_c = bus.booth_req & armed_q;

   // First eligible booth after rr_ptr, wrapping
   always_comb begin
      found_c    = 1'b0;
      winner_c   = '0;
      idx_c      = 0;
      elig_rot_c = '0;
      for (int unsigned k = 1; k <= NUM_BOOTHS; k++) begin
         idx_c      = (32'(rr_ptr_q) + k) % NUM_BOOTHS;
         elig_rot_c = eligible_c >> idx_c;
         if (!found_c && elig_rot_c[0]) begin
            found_c  = 1'b1;
            winner_c = IDW'(idx_c);
         end
      end
      sel_c     = NUM_BOOTHS'(1) << winner_c;
      cand_sh_c = bus.booth_cand >> (32'(winner_c) * 3);
      cand_c    = cand_sh_c[2:0];
   end

   // Next state; pulses are registered on the edge that enters GRANT
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      armed_d    = armed_q | ~bus.booth_req;
      ack_d      = '0;
      err_d      = '0;
      vote_d     = '0;
      hold_d     = hold_q;
      unique case (state_q)
         IDLE: begin
            if (bus.session_open && found_c) begin
               state_d    = GRANT;
               rr_ptr_d   = winner_c;
               grant_id_d = winner_c;
               armed_d    = armed_d & ~sel_c;
               if (cand_c < 3'd5) begin
                  ack_d  = sel_c;
                  vote_d = NVOTE'(1) << cand_c;
               end else begin
                  err_d  = sel_c;
               end
            end
         end
         GRANT: begin
            if (HOLDOFF > 0) begin
               state_d = HOLD;
               hold_d  = CNTW'(HOLDOFF - 1);
            end else begin
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (hold_q == '0) state_d = IDLE;
            else              hold_d  = hold_q - CNTW'(1);
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= IDW'(NUM_BOOTHS - 1);
         grant_id_q <= IDW'(NUM_BOOTHS - 1);
         armed_q    <= '1;
         ack_q      <= '0;
         err_q      <= '0;
         vote_q     <= '0;
         hold_q     <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         armed_q    <= armed_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         vote_q     <= vote_d;
         hold_q     <= hold_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.booth_ack = ack_q;
   assign bus.booth_err = err_q;
   assign bus.vote_A    = vote_q[0];
   assign bus.vote_B    = vote_q[1];
   assign bus.vote_C    = vote_q[2];
   assign bus.vote_D    = vote_q[3];
   assign bus.vote_E    = vote_q[4];
   assign bus.grant_id  = grant_id_q;
   assign bus.busy      = busy_q;

`ifdef BALLOT_TALLY_EN
   localparam int unsigned TW = 8;

   logic [TW-1:0] tally_q, tally_d;
   logic          sat_q, sat_d;

   // A vote pulse in GRANT is exactly one accepted ballot
   always_comb begin
      tally_d = tally_q;
      if (state_q == GRANT && |vote_q && tally_q != '1) tally_d = tally_q + TW'(1);
      sat_d = (tally_d == '1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tally_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         tally_q <= tally_d;
         sat_q   <= sat_d;
      end
   end

   assign bus.total_ballots = tally_q;
   assign bus.tally_sat     = sat_q;
`endif
endmodule

// File: tb/tb_ballot_scheduler.sv
// Randomised scoreboard bench for ballot_scheduler against a transaction-level model.
module tb_ballot_scheduler;
   localparam int unsigned N = 4;
   localparam int unsigned H = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ballot_scheduler_if #(.NUM_BOOTHS(N)) bus();

   ballot_scheduler #(.NUM_BOOTHS(N), .HOLDOFF(H)) dut (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   typedef struct {
      int cyc;
      int booth;
      int cand;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Booth-side stimulus state: 0 idle, 1 waiting for service, 2 served and lingering
   bit   breq[N];
   int   bc[N];
   int   bstate[N];
   int   bcnt[N];
   bit   session = 1'b0;
   int   sess_cnt = 0;
   bit   auto_req = 1'b1;
   bit   mon_en = 1'b0;

   // Reference model state
   int   m_rr;
   int   m_gid;
   bit   m_armed[N];
   int   next_free;
   int   last_sel;
   int   tally;
   bit   pend;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         bus.booth_req[i]        = breq[i];
         bus.booth_cand[3*i +: 3] = 3'(bc[i]);
      end
      bus.session_open = session;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_rr = N - 1;
      m_gid = N - 1;
      next_free = 0;
      last_sel = -1000;
      tally = 0;
      pend = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_armed[i] = 1'b1;
         breq[i] = 1'b0;
         bc[i] = 0;
         bstate[i] = 0;
         bcnt[i] = 0;
      end
   endtask

   // One arbitration opportunity per clock edge, spaced by the grant turnaround
   task automatic model_edge();
      bit found;
      if (pend) begin
         if (tally < 255) tally++;
         pend = 1'b0;
      end
      for (int i = 0; i < N; i++) if (!breq[i]) m_armed[i] = 1'b1;
      found = 1'b0;
      if (session && cyc >= next_free) begin
         for (int k = 1; k <= N; k++) begin
            int b;
            b = (m_rr + k) % N;
            if (!found && breq[b] && m_armed[b]) begin
               found = 1'b1;
               m_armed[b] = 1'b0;
               m_rr = b;
               m_gid = b;
               last_sel = cyc;
               next_free = cyc + int'(H) + 2;
               q.push_back('{cyc, b, bc[b]});
               pend = (bc[b] < 5);
               bstate[b] = 2;
               bcnt[b] = ($urandom_range(7) == 0) ? 20 : int'($urandom_range(3));
            end
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (bstate[i] == 0) begin
            if (auto_req && $urandom_range(3) == 0) begin
               bc[i] = ($urandom_range(9) < 8) ? int'($urandom_range(4)) : int'($urandom_range(7, 5));
               breq[i] = 1'b1;
               bstate[i] = 1;
            end
         end else if (bstate[i] == 2) begin
            if (bcnt[i] == 0) begin
               breq[i] = 1'b0;
               bstate[i] = 0;
            end else begin
               bcnt[i]--;
            end
         end
      end
      if (sess_cnt == 0) begin
         session = ($urandom_range(5) != 0) || !auto_req;
         sess_cnt = int'($urandom_range(15, 1));
      end else begin
         sess_cnt--;
      end
      @(posedge clk);
      cyc++;
      model_edge();
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a pulse
   initial begin
      exp_t       e;
      logic [4:0] v;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            v = {bus.vote_E, bus.vote_D, bus.vote_C, bus.vote_B, bus.vote_A};
            while (q.size() > 0 && q[0].cyc < cyc) begin
               e = q.pop_front();
               check("grant_cycle", 32'(cyc), 32'(e.cyc));
            end
            if (v != 0 || bus.booth_ack != 0 || bus.booth_err != 0) begin
               if (q.size() == 0) begin
                  check("spurious_pulse", {bus.booth_ack, bus.booth_err, v}, 32'd0);
               end else begin
                  e = q.pop_front();
                  check("grant_cycle", 32'(cyc), 32'(e.cyc));
                  check("booth_ack", 32'(bus.booth_ack), (e.cand < 5) ? 32'(1 << e.booth) : 32'd0);
                  check("booth_err", 32'(bus.booth_err), (e.cand < 5) ? 32'd0 : 32'(1 << e.booth));
                  check("vote", 32'(v), (e.cand < 5) ? 32'(1 << e.cand) : 32'd0);
               end
            end
            check("busy", 32'(bus.busy), 32'((cyc - last_sel) <= int'(H)));
            check("grant_id", 32'(bus.grant_id), 32'(m_gid));
`ifdef BALLOT_TALLY_EN
            check("total_ballots", 32'(bus.total_ballots), 32'(tally));
            check("tally_sat", 32'(bus.tally_sat), 32'(tally == 255));
`endif
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      bit found;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_ack", 32'(bus.booth_ack), 32'd0);
      check("rst_err", 32'(bus.booth_err), 32'd0);
      check("rst_vote", 32'({bus.vote_E, bus.vote_D, bus.vote_C, bus.vote_B, bus.vote_A}), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_grant_id", 32'(bus.grant_id), 32'(N - 1));
`ifdef BALLOT_TALLY_EN
      check("rst_total", 32'(bus.total_ballots), 32'd0);
      check("rst_sat", 32'(bus.tally_sat), 32'd0);
`endif
      mon_en = 1'b1;
      repeat (300) step();

      // Reset asserted in the middle of a valid GRANT cycle
      found = 1'b0;
      for (int t = 0; t < 400 && !found; t++) begin
         step();
         if (last_sel == cyc && q.size() > 0 && q[q.size()-1].cand < 5) found = 1'b1;
      end
      check("grant_before_reset", 32'(found), 32'd1);
      if (found) begin
         @(negedge clk);
         #2;
         rst_n = 1'b0;
         mon_en = 1'b0;
         #1;
         check("midrst_vote", 32'({bus.vote_E, bus.vote_D, bus.vote_C, bus.vote_B, bus.vote_A}), 32'd0);
         check("midrst_ack", 32'(bus.booth_ack), 32'd0);
         check("midrst_busy", 32'(bus.busy), 32'd0);
         model_reset();
         q.delete();
         repeat (2) @(posedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         #1;
         mon_en = 1'b1;
      end

      repeat (3000) step();
      auto_req = 1'b0;
      repeat (80) step();
      @(negedge clk);
      #1;
      check("queue_drained", 32'(q.size()), 32'd0);
`ifdef BALLOT_TALLY_EN
      check("tally_final", 32'(bus.total_ballots), 32'(tally));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
